wb_mem_port_arbiter: RTL and testbench

//  Two-master Wishbone arbiter that shares one memory-macro slave port between the CPU

---
 rtl/wb_mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_port_arbiter.sv
// Two-master Wishbone arbiter sharing one memory slave port between the instruction
// bus (I) and the data bus (D), with round-robin grant and a per-transfer watchdog.
module wb_mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   mi_adr_i,
   input  logic [DW-1:0]   mi_dat_i,
   input  logic            mi_we_i,
   input  logic            mi_cyc_i,
   input  logic            mi_stb_i,
   input  logic [DW/8-1:0] mi_sel_i,
   output logic [DW-1:0]   mi_dat_o,
   output logic            mi_ack_o,
   output logic            mi_err_o,
   input  logic [AW-1:0]   md_adr_i,
   input  logic [DW-1:0]   md_dat_i,
   input  logic            md_we_i,
   input  logic            md_cyc_i,
   input  logic            md_stb_i,
   input  logic [DW/8-1:0] md_sel_i,
   output logic [DW-1:0]   md_dat_o,
   output logic            md_ack_o,
   output logic            md_err_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   output logic [1:0]      gnt_o,
   output logic            timeout_o
);

   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_LIMIT = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          last_d_q, last_d_d;   // 1: the most recent grant went to D
   logic [WW-1:0] wdog_q, wdog_d;
   logic          toflag_q, toflag_d;

   logic sel_i, sel_d, term_en, slv_ack, slv_err, fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         wdog_q   <= '0;
         toflag_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         wdog_q   <= wdog_d;
         toflag_q <= toflag_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      case (state_q)
         IDLE: begin
            if (mi_cyc_i && md_cyc_i) begin
               state_d  = last_d_q ? GNT_I : GNT_D;
               last_d_d = ~last_d_q;
            end else if (mi_cyc_i) begin
               state_d  = GNT_I;
               last_d_d = 1'b0;
            end else if (md_cyc_i) begin
               state_d  = GNT_D;
               last_d_d = 1'b1;
            end
         end
         GNT_I:   if (!mi_cyc_i) state_d = IDLE;
         GNT_D:   if (!md_cyc_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_i   = (state_q == GNT_I);
      sel_d   = (state_q == GNT_D);
      gnt_o   = {sel_d, sel_i};
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      if (sel_i) begin
         s_adr_o = mi_adr_i;
         s_dat_o = mi_dat_i;
         s_we_o  = mi_we_i;
         s_sel_o = mi_sel_i;
         s_cyc_o = mi_cyc_i & ~toflag_q;
         s_stb_o = mi_stb_i & ~toflag_q;
      end else if (sel_d) begin
         s_adr_o = md_adr_i;
         s_dat_o = md_dat_i;
         s_we_o  = md_we_i;
         s_sel_o = md_sel_i;
         s_cyc_o = md_cyc_i & ~toflag_q;
         s_stb_o = md_stb_i & ~toflag_q;
      end
      // After a timeout the slave is considered dead until the master lets go.
      term_en   = (sel_i | sel_d) & ~toflag_q;
      slv_ack   = s_ack_i & term_en;
      slv_err   = s_err_i & term_en;
      fire      = (TIMEOUT != 0) && s_stb_o && !s_ack_i && !s_err_i && (wdog_q == WD_LIMIT);
      timeout_o = fire;
      mi_ack_o  = sel_i & slv_ack;
      mi_err_o  = sel_i & (slv_err | fire);
      mi_dat_o  = sel_i ? s_dat_i : '0;
      md_ack_o  = sel_d & slv_ack;
      md_err_o  = sel_d & (slv_err | fire);
      md_dat_o  = sel_d ? s_dat_i : '0;
   end

   always_comb begin
      wdog_d   = wdog_q;
      toflag_d = toflag_q;
      if (state_q == IDLE) begin
         wdog_d   = '0;
         toflag_d = 1'b0;
      end else if (s_ack_i || s_err_i) begin
         wdog_d = '0;
      end else if (fire) begin
         wdog_d   = '0;
         toflag_d = 1'b1;
      end else if (s_stb_o) begin
         wdog_d = wdog_q + WW'(1);
      end
   end

endmodule

// File: tb/tb_wb_mem_port_arbiter.sv
// Randomized bench for wb_mem_port_arbiter: random masters, a random-latency slave
// and random resets, compared every cycle against a transaction-level model.
module tb_wb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic [AW-1:0] mi_adr_i, md_adr_i, s_adr_o;
   logic [DW-1:0] mi_dat_i, md_dat_i, mi_dat_o, md_dat_o, s_dat_o, s_dat_i;
   logic mi_we_i, mi_cyc_i, mi_stb_i, md_we_i, md_cyc_i, md_stb_i;
   logic [DW/8-1:0] mi_sel_i, md_sel_i, s_sel_o;
   logic mi_ack_o, mi_err_o, md_ack_o, md_err_o;
   logic s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, timeout_o;
   logic [1:0] gnt_o;

   wb_mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mi_adr_i(mi_adr_i), .mi_dat_i(mi_dat_i), .mi_we_i(mi_we_i), .mi_cyc_i(mi_cyc_i),
      .mi_stb_i(mi_stb_i), .mi_sel_i(mi_sel_i), .mi_dat_o(mi_dat_o), .mi_ack_o(mi_ack_o),
      .mi_err_o(mi_err_o),
      .md_adr_i(md_adr_i), .md_dat_i(md_dat_i), .md_we_i(md_we_i), .md_cyc_i(md_cyc_i),
      .md_stb_i(md_stb_i), .md_sel_i(md_sel_i), .md_dat_o(md_dat_o), .md_ack_o(md_ack_o),
      .md_err_o(md_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Master BFMs: index 0 = I, 1 = D.
   bit            act [2];
   bit            cool[2];
   bit            stb [2];
   bit            we  [2];
   int            beats[2];
   logic [AW-1:0] adr [2];
   logic [DW-1:0] wd  [2];
   logic [3:0]    sel [2];

   // Reference model: owner 0 = none, 1 = I, 2 = D.
   int owner;
   bit last_was_d;
   int wait_cnt;
   bit dead;

   // Slave behaviour: terminates after sdly stalled strobe cycles.
   int scnt, sdly;
   bit rst_en;
   int n_timeouts, n_ties;

   task automatic model_reset();
      owner      = 0;
      last_was_d = 1'b0;
      wait_cnt   = 0;
      dead       = 1'b0;
      scnt       = 0;
      for (int i = 0; i < 2; i++) begin
         act[i]  = 1'b0;
         cool[i] = 1'b0;
         stb[i]  = 1'b0;
      end
   endtask

   task automatic run_cycle();
      int o, k, r;
      bit mcyc, mstb, e_scyc, e_sstb, term_ok, e_ack, e_serr, fire;
      bit e_err[2];
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      bit e_we;
      logic [3:0] e_sel;
      bit cyc_in[2];

      @(negedge clk);
      if (rst_en) begin
         if (rst_n && $urandom_range(0, 80) == 0) rst_n = 1'b0;
         else if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
      end
      if (!rst_n) model_reset();

      for (int i = 0; i < 2; i++) begin
         if (cool[i]) cool[i] = 1'b0;
         else if (!act[i] && rst_n && $urandom_range(0, 3) == 0) begin
            act[i]   = 1'b1;
            beats[i] = $urandom_range(1, 4);
            adr[i]   = $urandom;
            we[i]    = 1'($urandom_range(0, 1));
            sel[i]   = 4'($urandom_range(0, 15));
         end
         wd[i]  = $urandom;
         stb[i] = act[i] && ($urandom_range(0, 5) != 0);
      end
      mi_cyc_i = act[0]; mi_stb_i = stb[0]; mi_adr_i = adr[0]; mi_dat_i = wd[0];
      mi_we_i  = we[0];  mi_sel_i = sel[0];
      md_cyc_i = act[1]; md_stb_i = stb[1]; md_adr_i = adr[1]; md_dat_i = wd[1];
      md_we_i  = we[1];  md_sel_i = sel[1];
      cyc_in[0] = act[0];
      cyc_in[1] = act[1];

      o     = owner;
      k     = o - 1;
      mcyc  = (o != 0) ? act[k] : 1'b0;
      mstb  = (o != 0) ? stb[k] : 1'b0;
      e_adr = (o != 0) ? adr[k] : '0;
      e_dat = (o != 0) ? wd[k]  : '0;
      e_we  = (o != 0) ? we[k]  : 1'b0;
      e_sel = (o != 0) ? sel[k] : '0;
      e_scyc = mcyc && !dead;
      e_sstb = mstb && !dead;

      s_dat_i = $urandom;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      if (e_sstb) begin
         if (scnt >= sdly) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin s_ack_i = 1'b1; s_err_i = 1'b1; end
            else if (r < 3) s_err_i = 1'b1;
            else s_ack_i = 1'b1;
         end
      end else if ($urandom_range(0, 9) == 0) begin
         if ($urandom_range(0, 1) == 0) s_ack_i = 1'b1;
         else s_err_i = 1'b1;
      end

      term_ok = (o != 0) && !dead;
      e_ack   = s_ack_i && term_ok;
      e_serr  = s_err_i && term_ok;
      fire    = e_sstb && !s_ack_i && !s_err_i && (wait_cnt == TO - 1);
      e_err[0] = (o == 1) && (e_serr || fire);
      e_err[1] = (o == 2) && (e_serr || fire);

      #1;
      check("gnt",     64'(gnt_o),     64'((o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00));
      check("s_cyc",   64'(s_cyc_o),   64'(e_scyc));
      check("s_stb",   64'(s_stb_o),   64'(e_sstb));
      check("s_adr",   64'(s_adr_o),   64'(e_adr));
      check("s_dat",   64'(s_dat_o),   64'(e_dat));
      check("s_we",    64'(s_we_o),    64'(e_we));
      check("s_sel",   64'(s_sel_o),   64'(e_sel));
      check("mi_ack",  64'(mi_ack_o),  64'((o == 1) && e_ack));
      check("mi_err",  64'(mi_err_o),  64'(e_err[0]));
      check("mi_dat",  64'(mi_dat_o),  64'((o == 1) ? s_dat_i : '0));
      check("md_ack",  64'(md_ack_o),  64'((o == 2) && e_ack));
      check("md_err",  64'(md_err_o),  64'(e_err[1]));
      check("md_dat",  64'(md_dat_o),  64'((o == 2) ? s_dat_i : '0));
      check("timeout", 64'(timeout_o), 64'(fire));
      if (fire) n_timeouts++;

      if (!rst_n) return;

      if (e_sstb) begin
         if (s_ack_i || s_err_i || fire) begin
            scnt = 0;
            sdly = $urandom_range(0, 10);
         end else scnt++;
      end

      if (o == 0) begin
         wait_cnt = 0;
         dead     = 1'b0;
         if (cyc_in[0] && cyc_in[1]) begin
            owner = last_was_d ? 1 : 2;
            n_ties++;
         end else if (cyc_in[0]) owner = 1;
         else if (cyc_in[1]) owner = 2;
         if (owner != 0) last_was_d = (owner == 2);
      end else begin
         if (s_ack_i || s_err_i || fire) wait_cnt = 0;
         else if (e_sstb) wait_cnt++;
         if (fire) dead = 1'b1;
         if (!mcyc) owner = 0;
         if (e_ack && act[k]) begin
            beats[k]--;
            if (beats[k] <= 0) begin act[k] = 1'b0; cool[k] = 1'b1; end
         end
         if (e_err[k] && act[k]) begin act[k] = 1'b0; cool[k] = 1'b1; end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {mi_cyc_i, mi_stb_i, mi_we_i, md_cyc_i, md_stb_i, md_we_i, s_ack_i, s_err_i} = '0;
      mi_adr_i = '0; mi_dat_i = '0; mi_sel_i = '0;
      md_adr_i = '0; md_dat_i = '0; md_sel_i = '0;
      s_dat_i  = '0;
      n_timeouts = 0;
      n_ties     = 0;
      sdly   = 0;
      rst_en = 1'b0;
      model_reset();
      for (int c = 0; c < 3; c++) run_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 1500; c++) run_cycle();
      rst_en = 1'b1;
      for (int c = 0; c < 2500; c++) run_cycle();
      $display("timeouts seen=%0d, tied requests=%0d", n_timeouts, n_ties);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
